dm_cache_fsm: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller that sits between the CPU request interface and the line-granular backing memory.
- It is the initiator on the cache-to-memory interface (cache_def types). It issues line reads and writes, then waits for the memory's ready response.
- 16-byte (128-bit) lines, 32-bit CPU words, single outstanding request.

---
 rtl/dm_cache_fsm.sv | 141 ++++++++++++++
 tb/tb_dm_cache_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller.
// 16-byte lines, 32-bit CPU words, one outstanding request at a time.

package cache_def;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
endpackage

module dm_cache_fsm
  import cache_def::*;
#(
  parameter int NUM_LINES = 1024
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  cpu_req_type    cpu_req_i,
  output cpu_result_type cpu_res_o,
  output mem_req_type    mem_req_o,
  input  mem_data_type   mem_data_i
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [127:0]           data_mem [NUM_LINES];
  logic [31:0]            req_addr_q;
  mem_req_type            mem_req_q;

  // The request address is latched on acceptance so a CPU that drops valid
  // mid-miss cannot steer the fill into a different line.
  logic [INDEX_W-1:0] ridx;
  logic [TAG_W-1:0]   rtag;
  logic [1:0]         roff;
  logic               hit, cmp_hit, wr_hit, fill, unused_addr;

  assign ridx        = req_addr_q[4 +: INDEX_W];
  assign rtag        = req_addr_q[31 -: TAG_W];
  assign roff        = req_addr_q[3:2];
  assign unused_addr = ^req_addr_q[1:0];

  assign hit     = valid_q[ridx] && (tag_mem[ridx] == rtag);
  assign cmp_hit = (state_q == COMPARE_TAG) && cpu_req_i.valid && hit;
  assign wr_hit  = cmp_hit && cpu_req_i.rw;
  assign fill    = (state_q == ALLOCATE) && mem_data_i.ready;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cpu_req_i.valid) state_d = COMPARE_TAG;
      COMPARE_TAG: begin
        if (!cpu_req_i.valid || hit)           state_d = IDLE;
        else if (valid_q[ridx] && dirty_q[ridx]) state_d = WRITE_BACK;
        else                                     state_d = ALLOCATE;
      end
      WRITE_BACK:  if (mem_data_i.ready) state_d = ALLOCATE;
      ALLOCATE:    if (mem_data_i.ready) state_d = COMPARE_TAG;
      default:     state_d = IDLE;
    endcase
  end

  // CPU response: only the hit cycle in COMPARE_TAG answers.
  always_comb begin
    cpu_res_o = '0;
    if (cmp_hit) begin
      cpu_res_o.ready = 1'b1;
      cpu_res_o.data  = data_mem[ridx][{roff, 5'b0} +: 32];
    end
  end

  // Request latch, line status bits and memory request register.
  // valid pulses for one cycle on entry to a memory state; addr/data/rw hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      mem_req_q  <= '0;
    end else begin
      mem_req_q.valid <= 1'b0;
      if (state_q == IDLE && cpu_req_i.valid) req_addr_q <= cpu_req_i.addr;
      if (wr_hit) dirty_q[ridx] <= 1'b1;
      if (fill) begin
        valid_q[ridx] <= 1'b1;
        dirty_q[ridx] <= 1'b0;
      end
      if (state_q == COMPARE_TAG && state_d == WRITE_BACK) begin
        mem_req_q.valid <= 1'b1;
        mem_req_q.rw    <= 1'b1;
        mem_req_q.addr  <= {tag_mem[ridx], ridx, 4'b0};
        mem_req_q.data  <= data_mem[ridx];
      end else if (state_q != ALLOCATE && state_d == ALLOCATE) begin
        mem_req_q.valid <= 1'b1;
        mem_req_q.rw    <= 1'b0;
        mem_req_q.addr  <= {rtag, ridx, 4'b0};
      end
    end
  end

  // Tag and data arrays: no reset, written on write hit or line fill.
  always_ff @(posedge clk_i) begin
    if (wr_hit) data_mem[ridx][{roff, 5'b0} +: 32] <= cpu_req_i.data;
    if (fill) begin
      data_mem[ridx] <= mem_data_i.data;
      tag_mem[ridx]  <= rtag;
    end
  end

  assign mem_req_o = mem_req_q;
endmodule

// File: tb/tb_dm_cache_fsm.sv
// Directed bench for dm_cache_fsm with a line-granular memory responder.
module tb_dm_cache_fsm;
  import cache_def::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  cpu_req_type    cpu_req_i = '0;
  cpu_result_type cpu_res_o;
  mem_req_type    mem_req_o;
  mem_data_type   mem_data_i = '0;

  dm_cache_fsm #(.NUM_LINES(1024)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cpu_req_i(cpu_req_i),
    .cpu_res_o(cpu_res_o), .mem_req_o(mem_req_o), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [161:0] act, input logic [161:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Memory model: answers each valid cycle after mem_delay cycles.
  logic [127:0] mem_model [logic [31:0]];
  int           mem_delay = 3;
  int           cnt = 0;
  int           pulses = 0;
  mem_req_type  cur = '0;
  logic         p_rw   [$];
  logic [31:0]  p_addr [$];
  logic [127:0] p_data [$];

  always @(posedge clk_i) begin
    #1;
    mem_data_i.ready = 1'b0;
    if (mem_req_o.valid) begin
      pulses++;
      p_rw.push_back(mem_req_o.rw);
      p_addr.push_back(mem_req_o.addr);
      p_data.push_back(mem_req_o.data);
      cur = mem_req_o;
      cnt = mem_delay;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_data_i.ready = 1'b1;
        if (cur.rw) mem_model[cur.addr] = cur.data;
        else mem_data_i.data = mem_model.exists(cur.addr) ? mem_model[cur.addr] : '0;
      end
    end
  end

  task automatic clr_log();
    pulses = 0;
    p_rw.delete(); p_addr.delete(); p_data.delete();
  endtask

  // One CPU transaction; cycle 1 is the first cycle valid is seen in IDLE.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rw,
                        output logic [31:0] rd, output int cyc);
    bit got;
    got = 1'b0; rd = '0; cyc = 0;
    @(posedge clk_i); #1;
    clr_log();
    cpu_req_i = {a, d, rw, 1'b1};
    while (!got && cyc < 300) begin
      @(negedge clk_i); cyc++;
      if (cpu_res_o.ready) begin got = 1'b1; rd = cpu_res_o.data; end
    end
    chk("req_done", got, 1'b1);
    @(posedge clk_i); #1;
    cpu_req_i.valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                        input int exp_cyc, input int exp_pulses);
    logic [31:0] rd; int cyc;
    do_req(a, 32'h0, 1'b0, rd, cyc);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  // Raise a read, return once its memory pulse has been seen.
  task automatic start_read(input logic [31:0] a);
    int k;
    k = 0;
    @(posedge clk_i); #1;
    clr_log();
    cpu_req_i = {a, 32'h0, 1'b0, 1'b1};
    while (!mem_req_o.valid && k < 50) begin @(negedge clk_i); k++; end
    chk("pulse_seen", mem_req_o.valid, 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc, bad;
    mem_model[32'h0000_1000] = {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
    mem_model[32'h0000_5000] = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    mem_model[32'h0000_2010] = {96'h0, 32'h2010_0000};
    mem_model[32'h0000_2020] = {96'h0, 32'h2020_0000};
    mem_model[32'h0000_2030] = {96'h0, 32'h2030_0000};
    mem_model[32'h0000_0000] = {96'h0, 32'h0000_AAAA};
    mem_model[32'h0000_4000] = {96'h0, 32'h4000_BBBB};
    mem_model[32'h0000_3040] = {32'h3040_0003, 96'h0};
    mem_model[32'h0000_3050] = {64'h0, 32'h3050_0001, 32'h0};

    repeat (2) @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, '0);
    chk("rst_cpu_res", cpu_res_o, '0);
    rst_ni = 1'b1;

    // Cold read miss, then repeat read hits.
    mem_delay = 3;
    rd_chk("miss_1004", 32'h0000_1004, 32'h0B0B_0B0B, 7, 1);
    chk("miss_1004_addr", p_addr[0], 32'h0000_1000);
    chk("miss_1004_rw", p_rw[0], 1'b0);
    rd_chk("hit_1004", 32'h0000_1004, 32'h0B0B_0B0B, 2, 0);

    // Write hit dirties the line without memory traffic.
    do_req(32'h0000_1008, 32'hDEAD_BEEF, 1'b1, rd, cyc);
    chk("wr_hit_lat", cyc, 2);
    chk("wr_hit_pulses", pulses, 0);
    rd_chk("rd_after_wr", 32'h0000_1008, 32'hDEAD_BEEF, 2, 0);

    // Dirty conflict: write-back, then allocate.
    rd_chk("dirty_5008", 32'h0000_5008, 32'h5555_0002, 11, 2);
    chk("wb_rw", p_rw[0], 1'b1);
    chk("wb_addr", p_addr[0], 32'h0000_1000);
    chk("wb_data", p_data[0], {32'h0D0D_0D0D, 32'hDEAD_BEEF, 32'h0B0B_0B0B, 32'h0A0A_0A0A});
    chk("alloc_rw", p_rw[1], 1'b0);
    chk("alloc_addr", p_addr[1], 32'h0000_5000);
    // 0x5000 line is clean; returning to 0x1000 reads the written-back data.
    rd_chk("back_1008", 32'h0000_1008, 32'hDEAD_BEEF, 7, 1);
    chk("back_rw", p_rw[0], 1'b0);

    // Memory latency sweep.
    mem_delay = 1;  rd_chk("lat1",  32'h0000_2010, 32'h2010_0000, 5, 1);
    mem_delay = 5;  rd_chk("lat5",  32'h0000_2020, 32'h2020_0000, 9, 1);
    mem_delay = 20; rd_chk("lat20", 32'h0000_2030, 32'h2030_0000, 24, 1);

    // Clean conflict at index 0: allocate only.
    mem_delay = 2;
    rd_chk("idx0_fill", 32'h0000_0000, 32'h0000_AAAA, 6, 1);
    rd_chk("idx0_conf", 32'h0000_4000, 32'h4000_BBBB, 6, 1);
    chk("idx0_conf_rw", p_rw[0], 1'b0);
    chk("idx0_conf_addr", p_addr[0], 32'h0000_4000);

    // Valid dropped mid-miss: fill completes silently, then hits.
    mem_delay = 5;
    start_read(32'h0000_3050);
    cpu_req_i.valid = 1'b0;
    bad = 0;
    repeat (15) begin @(negedge clk_i); if (cpu_res_o.ready) bad++; end
    chk("drop_no_ready", bad, 0);
    rd_chk("drop_then_hit", 32'h0000_3054, 32'h3050_0001, 2, 0);

    // Reset during the allocate wait; the late memory ready is ignored.
    mem_delay = 20;
    start_read(32'h0000_3040);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    cpu_req_i.valid = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req_o, '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk_i);
      if (cpu_res_o.ready || mem_req_o.valid) bad++;
    end
    chk("midrst_quiet", bad, 0);
    mem_delay = 2;
    rd_chk("midrst_rereq", 32'h0000_304C, 32'h3040_0003, 6, 1);
    chk("midrst_rereq_addr", p_addr[0], 32'h0000_3040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
